mem_port_arbiter3: RTL and testbench
====================================

Name: mem_port_arbiter3

Overview:
Shares the single memory port (12-bit address, 8-bit write data) among three requesters: 0 = instruction fetch, 1 = data load/store, 2 = DMA/debug. Drives the 2-bit select for the 3-input address and write-data muxes in front of memory. Sequences one memory transaction at a time with a req/ack handshake. Uses round-robin fairness, an optional lock for read-modify-write, and a timeout watchdog.

Parameters:
TIMEOUT, 15, memory-ack wait limit in cycles; 1..255; counter width 8 bits.
LOCK_MAX, 2, maximum consecutive locked re-grants to one requester before forced rotation.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  3  per-requester transaction request; level, held until done.
lock  input  3  per-requester: keep grant for the next transaction.
mem_ack  input  1  memory completion, one-cycle pulse.
gnt  output  3  one-hot grant; all zero when idle.
sel  output  2  mux select: 00 = requester 0, 01 = requester 1, 10 = requester 2.
mem_req  output  1  memory strobe, high during ACCESS.
done  output  3  one-cycle completion pulse to the granted requester.
err  output  1  one-cycle pulse on timeout abort, coincident with done.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE; gnt=000, sel=00, mem_req=0, done=000, err=0, busy=0; rr pointer last=2, so requester 0 wins first; lock count=0; timeout count=0.
- States: IDLE -> SETUP -> ACCESS -> DONE -> IDLE or SETUP.
- IDLE: if req!=0, pick the winner by round-robin starting at (last+1) mod 3. Register gnt and sel, go to SETUP. If req=0, stay.
- SETUP: one cycle so the mux outputs settle. mem_req=0, gnt and sel stable. Go to ACCESS.
- ACCESS: mem_req=1, timeout count increments each cycle.
  - mem_ack=1: go to DONE.
  - count reaches TIMEOUT with no ack: go to DONE with an abort flag.
- DONE: done[g]=1 for one cycle; err=1 if aborted. mem_req=0. Update last=g and clear the timeout count.
  - lock[g]=1, req[g]=1 and lock count<LOCK_MAX: increment lock count, keep gnt and sel, go straight to SETUP.
  - Otherwise: clear lock count, clear gnt, go to IDLE.
- Latency: req sampled in IDLE at cycle 0; gnt/sel valid at cycle 1; mem_req rises at cycle 2; ack at cycle n gives done at cycle n+1. Minimum 4 cycles from request to done with ack at cycle 2.
- gnt and sel change only on the IDLE->SETUP transition; they never change while mem_req=1.
- mem_ack outside ACCESS is ignored.
- A req drop during SETUP or ACCESS is ignored: the transaction completes and done still pulses.
- A new req arriving during a transaction waits; arbitration happens only in IDLE. Exception: locked re-grant in DONE bypasses arbitration.
- Ack on the same cycle the timeout count reaches TIMEOUT: treat as success, err=0.
- Reset mid-ACCESS: immediate return to reset values; the memory side must tolerate a dropped strobe.
- Invariants: $onehot0(gnt); gnt!=0 whenever busy; sel never 11.

Decomposition:
- Package arb_pkg:
  - NREQ=3.
  - state enum {IDLE, SETUP, ACCESS, DONE}.
  - sel encoding constants SEL_R0=2'b00, SEL_R1=2'b01, SEL_R2=2'b10, matching the 3-input mux select convention.
- Sub-module rr_pick3: combinational; inputs req[2:0] and last[1:0]; outputs one-hot win[2:0] and win_idx[1:0]. Top level holds the FSM, counters and registers.

Test Plan:
- Reset, then req=001, ack 3 cycles after mem_req rises -> gnt=001 and sel=00 at cycle 1; mem_req cycles 2-4; done=001 at cycle 5; busy low at cycle 6.
- req=111 held, ack always 1 cycle after mem_req -> grant order 0,1,2,0,1,2; each done pulse hits only the granted bit.
- req=011, lock[1]=1, starting after requester 0 served -> requester 1 granted 3 consecutive times (initial + LOCK_MAX=2), then requester 0 granted; no IDLE cycle between locked grants.
- req=100, mem_ack never asserted -> mem_req high exactly 15 cycles; done=100 and err=1 on the same cycle; next req=100 regranted normally.
- req=010, deassert req during ACCESS, ack later -> done=010 still pulses once; spurious mem_ack in IDLE produces no done.
- rst_n asserted mid-ACCESS for 1 cycle -> all outputs zero asynchronously; after release, req=011 grants requester 0 first.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg
//    Shared definitions for the three-requester memory port arbiter:
//    requester count, FSM state encoding and the select codes used by the
//    3-input address / write-data muxes in front of memory.
package arb_pkg;

   localparam int NREQ = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } arb_state_t;

   // Mux select codes; the select value equals the requester index.
   localparam logic [1:0] SEL_R0 = 2'b00;
   localparam logic [1:0] SEL_R1 = 2'b01;
   localparam logic [1:0] SEL_R2 = 2'b10;

endpackage

// File: rtl/rr_pick3.sv
// rr_pick3
//    Combinational round-robin picker for three requesters. The search
//    starts at the requester after the one served last and wraps around.
// Ports:
//    req     [2:0]  active requests
//    last    [1:0]  index of the requester served most recently
//    win     [2:0]  one-hot winner, zero when no request is active
//    win_idx [1:0]  winner index, used directly as the mux select
module rr_pick3
   import arb_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      last,
   output logic [NREQ-1:0] win,
   output logic [1:0]      win_idx
);

   always_comb begin
      win     = '0;
      win_idx = SEL_R0;
      case (last)
         2'd0: begin
            if (req[1])      begin win = 3'b010; win_idx = SEL_R1; end
            else if (req[2]) begin win = 3'b100; win_idx = SEL_R2; end
            else if (req[0]) begin win = 3'b001; win_idx = SEL_R0; end
         end
         2'd1: begin
            if (req[2])      begin win = 3'b100; win_idx = SEL_R2; end
            else if (req[0]) begin win = 3'b001; win_idx = SEL_R0; end
            else if (req[1]) begin win = 3'b010; win_idx = SEL_R1; end
         end
         // last = 2 (and the unused code 3) start the search at requester 0
         default: begin
            if (req[0])      begin win = 3'b001; win_idx = SEL_R0; end
            else if (req[1]) begin win = 3'b010; win_idx = SEL_R1; end
            else if (req[2]) begin win = 3'b100; win_idx = SEL_R2; end
         end
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter3.sv
// mem_port_arbiter3
//    Shares one memory port among instruction fetch (0), data load/store (1)
//    and DMA/debug (2). One transaction at a time is sequenced through
//    IDLE -> SETUP -> ACCESS -> DONE, with round-robin fairness, an optional
//    lock for read-modify-write sequences and a memory-ack timeout.
// Ports:
//    clk      system clock, rising edge
//    rst_n    asynchronous active-low reset
//    req      per-requester level request, held until done
//    lock     per-requester request to keep the grant for the next transaction
//    mem_ack  memory completion pulse, honoured only in ACCESS
//    gnt      one-hot grant, zero when idle
//    sel      mux select (00/01/10 = requester 0/1/2)
//    mem_req  memory strobe, high during ACCESS
//    done     one-cycle completion pulse to the granted requester
//    err      one-cycle timeout abort flag, coincident with done
//    busy     high in every state except IDLE
module mem_port_arbiter3
   import arb_pkg::*;
#(
   parameter int TIMEOUT  = 15,
   parameter int LOCK_MAX = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] lock,
   input  logic            mem_ack,
   output logic [NREQ-1:0] gnt,
   output logic [1:0]      sel,
   output logic            mem_req,
   output logic [NREQ-1:0] done,
   output logic            err,
   output logic            busy
);

   localparam logic [7:0] TIMEOUT_W  = 8'(TIMEOUT);
   localparam logic [7:0] LOCK_MAX_W = 8'(LOCK_MAX);

   arb_state_t      state;
   arb_state_t      state_next;
   logic [NREQ-1:0] gnt_q;
   logic [1:0]      sel_q;
   logic [1:0]      last_q;
   logic [7:0]      lock_cnt;
   logic [7:0]      to_cnt;
   logic            abort_q;

   logic [NREQ-1:0] win;
   logic [1:0]      win_idx;
   logic            to_hit;
   logic            relock;

   rr_pick3 u_pick (
      .req     (req),
      .last    (last_q),
      .win     (win),
      .win_idx (win_idx)
   );

   // The count is compared one step ahead so ACCESS lasts exactly TIMEOUT
   // cycles when memory never answers.
   assign to_hit = (to_cnt + 8'd1) == TIMEOUT_W;

   // Locked re-grant: the current owner still requests, asks for the lock
   // and has not yet used up its consecutive re-grant allowance.
   assign relock = (|(lock & req & gnt_q)) && (lock_cnt < LOCK_MAX_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (|req) state_next = SETUP;
         SETUP:   state_next = ACCESS;
         ACCESS:  if (mem_ack || to_hit) state_next = DONE;
         DONE:    state_next = relock ? SETUP : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Grant, round-robin pointer, lock and timeout bookkeeping. Grant and
   // select are loaded only when leaving IDLE, so they stay stable for the
   // whole transaction (and across locked re-grants).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q    <= '0;
         sel_q    <= SEL_R0;
         last_q   <= 2'd2;
         lock_cnt <= 8'd0;
         to_cnt   <= 8'd0;
         abort_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt_q <= win;
                  sel_q <= win_idx;
               end
            end
            ACCESS: begin
               to_cnt <= to_cnt + 8'd1;
               // An ack on the timeout cycle still counts as success.
               if (!mem_ack && to_hit) abort_q <= 1'b1;
            end
            DONE: begin
               last_q  <= sel_q;
               to_cnt  <= 8'd0;
               abort_q <= 1'b0;
               if (relock) begin
                  lock_cnt <= lock_cnt + 8'd1;
               end else begin
                  lock_cnt <= 8'd0;
                  gnt_q    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign sel     = sel_q;
   assign mem_req = (state == ACCESS);
   assign done    = (state == DONE) ? gnt_q : '0;
   assign err     = (state == DONE) && abort_q;
   assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter3.sv
// tb_mem_port_arbiter3
//    Directed bench for mem_port_arbiter3: hand-computed expected outputs
//    checked one clock step at a time, sampled 1 time unit after each
//    rising edge.
module tb_mem_port_arbiter3;

   logic       clk;
   logic       rst_n;
   logic [2:0] req;
   logic [2:0] lock;
   logic       mem_ack;
   logic [2:0] gnt;
   logic [1:0] sel;
   logic       mem_req;
   logic [2:0] done;
   logic       err;
   logic       busy;

   int vectors     = 0;
   int miscompares = 0;

   mem_port_arbiter3 #(.TIMEOUT(15), .LOCK_MAX(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .lock    (lock),
      .mem_ack (mem_ack),
      .gnt     (gnt),
      .sel     (sel),
      .mem_req (mem_req),
      .done    (done),
      .err     (err),
      .busy    (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation did not finish");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] r, input logic [2:0] l, input logic a);
      req     = r;
      lock    = l;
      mem_ack = a;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Expected fields in order: gnt, sel, mem_req, done, err, busy
   task automatic checkState(input string tag, input logic [2:0] eg, input logic [1:0] es,
                             input logic em, input logic [2:0] ed, input logic ee, input logic eb);
      checkOutput(tag, {5'b0, gnt, sel, mem_req, done, err, busy},
                       {5'b0, eg, es, em, ed, ee, eb});
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      #1;
      checkState("reset", 3'b000, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b1;
      applyStimulus(3'b000, 3'b000, 1'b0);
      #2;
      resetDut();
      checkState("idle_after_reset", 3'b000, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);

      // Single request, ack on the third ACCESS cycle
      applyStimulus(3'b001, 3'b000, 1'b0);
      tick(); checkState("t1_c1", 3'b001, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1);
      tick(); checkState("t1_c2", 3'b001, 2'b00, 1'b1, 3'b000, 1'b0, 1'b1);
      tick(); checkState("t1_c3", 3'b001, 2'b00, 1'b1, 3'b000, 1'b0, 1'b1);
      tick(); checkState("t1_c4", 3'b001, 2'b00, 1'b1, 3'b000, 1'b0, 1'b1);
      applyStimulus(3'b001, 3'b000, 1'b1);
      tick(); checkState("t1_c5", 3'b001, 2'b00, 1'b0, 3'b001, 1'b0, 1'b1);
      applyStimulus(3'b000, 3'b000, 1'b0);
      tick(); checkState("t1_c6", 3'b000, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);

      // All three requesting: strict rotation 0,1,2,0,1,2 from reset
      resetDut();
      applyStimulus(3'b111, 3'b000, 1'b0);
      for (int k = 0; k < 6; k++) begin
         logic [2:0] eg;
         logic [1:0] es;
         eg = 3'b001 << (k % 3);
         es = 2'(k % 3);
         tick(); checkState("t2_setup", eg, es, 1'b0, 3'b000, 1'b0, 1'b1);
         tick(); checkState("t2_access", eg, es, 1'b1, 3'b000, 1'b0, 1'b1);
         mem_ack = 1'b1;
         tick(); checkState("t2_done", eg, es, 1'b0, eg, 1'b0, 1'b1);
         mem_ack = 1'b0;
         tick(); checkState("t2_idle", 3'b000, es, 1'b0, 3'b000, 1'b0, 1'b0);
      end

      // Lock: requester 0 served first, then requester 1 three times back to back
      applyStimulus(3'b011, 3'b010, 1'b0);
      tick(); checkState("t3_r0_setup", 3'b001, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1);
      tick(); mem_ack = 1'b1;
      tick(); checkState("t3_r0_done", 3'b001, 2'b00, 1'b0, 3'b001, 1'b0, 1'b1);
      mem_ack = 1'b0;
      tick(); checkState("t3_r0_idle", 3'b000, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
      for (int j = 0; j < 3; j++) begin
         tick(); checkState("t3_r1_setup", 3'b010, 2'b01, 1'b0, 3'b000, 1'b0, 1'b1);
         tick(); checkState("t3_r1_access", 3'b010, 2'b01, 1'b1, 3'b000, 1'b0, 1'b1);
         mem_ack = 1'b1;
         tick(); checkState("t3_r1_done", 3'b010, 2'b01, 1'b0, 3'b010, 1'b0, 1'b1);
         mem_ack = 1'b0;
      end
      tick(); checkState("t3_forced_idle", 3'b000, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0);
      tick(); checkState("t3_r0_again", 3'b001, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1);
      tick(); mem_ack = 1'b1;
      tick(); checkState("t3_r0_done2", 3'b001, 2'b00, 1'b0, 3'b001, 1'b0, 1'b1);
      applyStimulus(3'b000, 3'b000, 1'b0);
      tick();

      // Timeout: no ack, strobe held exactly 15 cycles, then regrant normally
      applyStimulus(3'b100, 3'b000, 1'b0);
      tick(); checkState("t4_setup", 3'b100, 2'b10, 1'b0, 3'b000, 1'b0, 1'b1);
      for (int i = 0; i < 15; i++) begin
         tick(); checkState("t4_wait", 3'b100, 2'b10, 1'b1, 3'b000, 1'b0, 1'b1);
      end
      tick(); checkState("t4_abort", 3'b100, 2'b10, 1'b0, 3'b100, 1'b1, 1'b1);
      tick(); checkState("t4_idle", 3'b000, 2'b10, 1'b0, 3'b000, 1'b0, 1'b0);
      tick(); checkState("t4_regrant", 3'b100, 2'b10, 1'b0, 3'b000, 1'b0, 1'b1);
      tick(); mem_ack = 1'b1;
      tick(); checkState("t4_ok_done", 3'b100, 2'b10, 1'b0, 3'b100, 1'b0, 1'b1);
      applyStimulus(3'b000, 3'b000, 1'b0);
      tick();

      // Request dropped mid-transaction still completes; stray ack in IDLE ignored
      applyStimulus(3'b010, 3'b000, 1'b0);
      tick(); checkState("t5_setup", 3'b010, 2'b01, 1'b0, 3'b000, 1'b0, 1'b1);
      tick(); applyStimulus(3'b000, 3'b000, 1'b0);
      tick(); checkState("t5_access", 3'b010, 2'b01, 1'b1, 3'b000, 1'b0, 1'b1);
      mem_ack = 1'b1;
      tick(); checkState("t5_done", 3'b010, 2'b01, 1'b0, 3'b010, 1'b0, 1'b1);
      mem_ack = 1'b0;
      tick(); checkState("t5_idle", 3'b000, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0);
      mem_ack = 1'b1;
      tick(); checkState("t5_stray_ack", 3'b000, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0);
      mem_ack = 1'b0;
      tick(); checkState("t5_stray_after", 3'b000, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0);

      // Reset mid-ACCESS clears everything without waiting for a clock
      applyStimulus(3'b001, 3'b000, 1'b0);
      tick(); tick();
      checkState("t6_access", 3'b001, 2'b00, 1'b1, 3'b000, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1 checkState("t6_async_reset", 3'b000, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
      applyStimulus(3'b011, 3'b000, 1'b0);
      tick();
      rst_n = 1'b1;
      tick(); checkState("t6_first_grant", 3'b001, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
